// File: rtl/proc_pkg.sv
// Shared constants for the simple processor controller: opcodes, FSM states and bus-source indices.
// Pure definitions; no logic, no latency.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam int SEL_G   = 8;
    localparam int SEL_DIN = 9;

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-bit binary to 8-bit one-hot decoder with enable; all-zero when disabled.
// Purely combinational, zero latency, no flow control.
module dec3to8 (
    input  logic       i_en,
    input  logic [2:0] i_bin,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_bin] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Four-state control FSM for a mv/mvi/add/sub datapath; outputs are decoded from state, Run and IR.
// Done follows a fetch by 1 cycle (mv/mvi/NOP) or 3 cycles (add/sub); Run is only looked at in T0.
module proc_control
    import proc_pkg::*;
(
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    output logic [9:0] Control,
    output logic [7:0] Rin,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       IRin,
    output logic       Done
);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  w_op;
    logic [7:0]  w_x_sel;
    logic [7:0]  w_y_sel;
    logic [9:0]  w_ctrl;
    logic [7:0]  w_rin;
    logic        w_ain;
    logic        w_gin;
    logic        w_addsub;
    logic        w_irin;
    logic        w_done;

    assign w_op = IR[8:6];

    // Decoders are disabled during reset so no bus source can be selected then.
    dec3to8 u_dec_x (
        .i_en     (Resetn),
        .i_bin    (IR[5:3]),
        .o_onehot (w_x_sel)
    );

    dec3to8 u_dec_y (
        .i_en     (Resetn),
        .i_bin    (IR[2:0]),
        .o_onehot (w_y_sel)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ctrl   = '0;
        w_rin    = '0;
        w_ain    = 1'b0;
        w_gin    = 1'b0;
        w_addsub = 1'b0;
        w_irin   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            T0: begin
                w_irin = Run;
                if (Run) begin
                    w_next = T1;
                end
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_ctrl[7:0] = w_y_sel;
                        w_rin       = w_x_sel;
                        w_done      = 1'b1;
                        w_next      = T0;
                    end
                    OP_MVI: begin
                        w_ctrl[SEL_DIN] = 1'b1;
                        w_rin           = w_x_sel;
                        w_done          = 1'b1;
                        w_next          = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        w_ctrl[7:0] = w_x_sel;
                        w_ain       = 1'b1;
                        w_next      = T2;
                    end
                    default: begin
                        w_done = 1'b1;
                        w_next = T0;
                    end
                endcase
            end
            // T2/T3 are entered only from add/sub, so the opcode needs no re-check here.
            T2: begin
                w_ctrl[7:0] = w_y_sel;
                w_gin       = 1'b1;
                w_addsub    = IR[6];
                w_next      = T3;
            end
            T3: begin
                w_ctrl[SEL_G] = 1'b1;
                w_rin         = w_x_sel;
                w_done        = 1'b1;
                w_next        = T0;
            end
            default: begin
                w_next = T0;
            end
        endcase
    end

    assign Control = Resetn ? w_ctrl   : '0;
    assign Rin     = Resetn ? w_rin    : '0;
    assign Ain     = Resetn & w_ain;
    assign Gin     = Resetn & w_gin;
    assign AddSub  = Resetn & w_addsub;
    assign IRin    = Resetn & w_irin;
    assign Done    = Resetn & w_done;

endmodule

// File: doc/proc_control.md
PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 Run  input  1  start request, sampled only in state T0.
REQ-005 IR  input  9  instruction word {III opcode, XXX dest/src-A reg, YYY src-B reg}, valid from the cycle after IRin.
REQ-006 Control  output  10  one-hot bus-source select: bits 0-7 = R0-R7, bit 8 = G, bit 9 = DIN; all-zero = no driver.
REQ-007 Rin  output  8  one-hot register load enable for R0-R7.
REQ-008 Ain  output  1  load ALU operand register A from Bus.
REQ-009 Gin  output  1  load ALU result register G.
REQ-010 AddSub  output  1  ALU op select: 0 = add, 1 = subtract; meaningful only with Gin.
REQ-011 IRin  output  1  load instruction register from DIN.
REQ-012 Done  output  1  one-cycle pulse marking the final cycle of an instruction.

Function
REQ-013 The FSM SHALL have four states T0 (idle/fetch), T1, T2, T3, held in a 2-bit register.
REQ-014 Outputs SHALL be combinational from state, Run and IR; all are 0 unless listed below for the current state and opcode.
REQ-015 T0: IRin = Run; Run = 1 -> T1, else stay in T0.
REQ-016 Opcodes: 000 mv (Rx <- Ry), 001 mvi (Rx <- DIN), 010 add (Rx <- Rx + Ry), 011 sub (Rx <- Rx - Ry); 100-111 are NOP.
REQ-017 T1 mv: Control[Y] = 1, Rin[X] = 1, Done = 1 -> T0.
REQ-018 T1 mvi: Control[9] = 1, Rin[X] = 1, Done = 1 -> T0.
REQ-019 T1 add/sub: Control[X] = 1, Ain = 1 -> T2.
REQ-020 T2 add/sub: Control[Y] = 1, Gin = 1, AddSub = IR[6] (0 add, 1 sub) -> T3.
REQ-021 T3 add/sub: Control[8] = 1, Rin[X] = 1, Done = 1 -> T0.
REQ-022 T1 NOP: Done = 1, no other output set -> T0.
REQ-023 Latency from Run sampled high in T0 to Done SHALL be 1 cycle for mv/mvi/NOP and 3 cycles for add/sub.
REQ-024 Control SHALL never have more than one bit set, and Rin SHALL never have more than one bit set.
REQ-025 Run changing while in T1-T3 SHALL have no effect; the instruction completes.
REQ-026 With Run held high, a new fetch (IRin = 1) SHALL occur in the cycle immediately after Done (back-to-back).
REQ-027 X = Y (e.g. add R3,R3) SHALL be legal and sequence exactly as REQ-019 to REQ-021.
REQ-028 States T2 and T3 SHALL be reachable only via add/sub; an illegal state encoding SHALL not occur (2 bits, 4 states).

Reset
REQ-029 Resetn low SHALL force state to T0 asynchronously, at any state including mid-instruction.
REQ-030 While Resetn is low, all outputs SHALL be 0 (IRin gated by Resetn).
REQ-031 After Resetn rises, the first Run = 1 sampled at a clock edge SHALL start a fetch; an aborted instruction SHALL not resume.

Structure
REQ-032 Package proc_pkg SHALL hold opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB), state encodings T0-T3, and Control bit indices SEL_G = 8, SEL_DIN = 9.
REQ-033 One sub-module dec3to8 (3-bit binary to 8-bit one-hot, with enable) SHALL produce the X/Y register selects; it is instantiated twice.
REQ-034 The state register SHALL be the only sequential element.

Verification
REQ-035 Reset, Run = 1, IR = 000_010_101 (mv R2,R5) -> T0: IRin = 1; T1: Control = 0000100000, Rin = 00000100, Done = 1; back in T0.
REQ-036 IR = 001_111_000 (mvi R7) -> T1: Control = 1000000000, Rin = 10000000, Done = 1.
REQ-037 IR = 011_001_110 (sub R1,R6) -> T1: Control = 0000000010, Ain = 1; T2: Control = 0001000000, Gin = 1, AddSub = 1; T3: Control = 0100000000, Rin = 00000010, Done = 1.
REQ-038 Run pulsed 1 cycle then 0 during add -> still completes in T3 with Done; no IRin until Run is high again in T0.
REQ-039 Resetn driven low in T2 of an add -> immediately all outputs 0 and state T0; after release, no Gin/Done from the aborted add.
REQ-040 IR = 110_000_000 (NOP) with Run held high -> T1: Done only; next cycle IRin = 1; a checker asserts the one-hot constraint on Control/Rin on every cycle.
